// File: rtl/integral_pkg.sv
// Shared types for the integral-image row chain: the pixel position record,
// the feeder state encoding, and the raster-order position step helper.
package integral_pkg;

   localparam int ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } feeder_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] col;
      logic [ADDR_WIDTH-1:0] row;
   } pos_t;

   // Raster successor of p; the row wraps so the counter never leaves the frame.
   function automatic pos_t next_pos(input pos_t p,
                                     input logic [ADDR_WIDTH-1:0] col_last,
                                     input logic [ADDR_WIDTH-1:0] row_last);
      pos_t n;
      if (p.col == col_last) begin
         n.col = {ADDR_WIDTH{1'b0}};
         if (p.row == row_last) begin
            n.row = {ADDR_WIDTH{1'b0}};
         end else begin
            n.row = p.row + ADDR_WIDTH'(1);
         end
      end else begin
         n.col = p.col + ADDR_WIDTH'(1);
         n.row = p.row;
      end
      return n;
   endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Column/row position of the next pixel to be written, with synchronous clear,
// restart-after-origin (used when a start-of-frame pixel takes (0,0)) and a last-pixel flag.
module frame_position_counter
   import integral_pkg::*;
#(
   parameter int FRAME_WIDTH  = 10,
   parameter int FRAME_HEIGHT = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  restart,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] col,
   output logic [ADDR_WIDTH-1:0] row,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(FRAME_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(FRAME_HEIGHT - 1);
   localparam pos_t ORIGIN = '{col: {ADDR_WIDTH{1'b0}}, row: {ADDR_WIDTH{1'b0}}};

   pos_t pos_r;
   pos_t pos_next_s;

   // Next-position selection: clear wins, restart steps past the origin, advance steps once.
   always_comb begin
      pos_next_s = pos_r;
      if (clear) begin
         pos_next_s = ORIGIN;
      end else if (restart) begin
         pos_next_s = next_pos(ORIGIN, COL_LAST, ROW_LAST);
      end else if (advance) begin
         pos_next_s = next_pos(pos_r, COL_LAST, ROW_LAST);
      end else begin
         pos_next_s = pos_r;
      end
   end

   // Position register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_r <= ORIGIN;
      end else begin
         pos_r <= pos_next_s;
      end
   end

   assign col  = pos_r.col;
   assign row  = pos_r.row;
   assign last = (pos_r.col == COL_LAST) && (pos_r.row == ROW_LAST);

endmodule

// File: rtl/integral_pixel_feeder.sv
// Front of the integral-image row chain: frames the camera pixel stream, writes
// zero-extended pixels into the first row stage and flags complete windows and frame end.
module integral_pixel_feeder
   import integral_pkg::*;
#(
   parameter int DATA_WIDTH_8        = 8,
   parameter int DATA_WIDTH_16       = 16,
   parameter int FRAME_CAMERA_WIDTH  = 10,
   parameter int FRAME_CAMERA_HEIGHT = 10,
   parameter int INTEGRAL_WIDTH      = 3,
   parameter int INTEGRAL_HEIGHT     = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH_8-1:0]  i_pixel,
   input  logic                     i_valid,
   input  logic                     i_sof,
   input  logic                     i_stall,
   output logic                     o_ready,
   output logic                     o_wen,
   output logic [DATA_WIDTH_16-1:0] o_fifo_in,
   output logic [ADDR_WIDTH-1:0]    o_col,
   output logic [ADDR_WIDTH-1:0]    o_row,
   output logic                     o_window_valid,
   output logic                     o_frame_end,
   output logic                     o_sof_error
);

   localparam logic [ADDR_WIDTH-1:0] WIN_COL_MIN = ADDR_WIDTH'(INTEGRAL_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] WIN_ROW_MIN = ADDR_WIDTH'(INTEGRAL_HEIGHT - 1);
   localparam logic ORIGIN_IS_LAST = (FRAME_CAMERA_WIDTH == 1) && (FRAME_CAMERA_HEIGHT == 1);

   feeder_state_t         state_r;
   logic                  accept_s;
   logic                  sof_take_s;
   logic                  pix_take_s;
   logic                  write_s;
   logic                  last_write_s;
   logic                  clear_s;
   logic                  restart_s;
   logic                  advance_s;
   logic [ADDR_WIDTH-1:0] cnt_col_s;
   logic [ADDR_WIDTH-1:0] cnt_row_s;
   logic                  cnt_last_s;
   logic [ADDR_WIDTH-1:0] wr_col_s;
   logic [ADDR_WIDTH-1:0] wr_row_s;

   // Held low during reset so every output reads 0 while it is asserted.
   assign o_ready  = ~reset & ((state_r == IDLE) | (state_r == ACTIVE)) & ~i_stall;
   assign accept_s = i_valid & o_ready;

   // Write decode: a start-of-frame pixel always lands at (0,0); plain pixels only count while ACTIVE.
   always_comb begin
      sof_take_s   = accept_s & i_sof;
      pix_take_s   = accept_s & ~i_sof & (state_r == ACTIVE);
      write_s      = sof_take_s | pix_take_s;
      last_write_s = (sof_take_s & ORIGIN_IS_LAST) | (pix_take_s & cnt_last_s);
      restart_s    = sof_take_s & ~last_write_s;
      advance_s    = pix_take_s & ~last_write_s;
      clear_s      = last_write_s | (state_r == DONE);
      if (sof_take_s) begin
         wr_col_s = {ADDR_WIDTH{1'b0}};
         wr_row_s = {ADDR_WIDTH{1'b0}};
      end else begin
         wr_col_s = cnt_col_s;
         wr_row_s = cnt_row_s;
      end
   end

   frame_position_counter #(
      .FRAME_WIDTH  (FRAME_CAMERA_WIDTH),
      .FRAME_HEIGHT (FRAME_CAMERA_HEIGHT)
   ) u_pos (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_s),
      .restart (restart_s),
      .advance (advance_s),
      .col     (cnt_col_s),
      .row     (cnt_row_s),
      .last    (cnt_last_s)
   );

   // Feeder FSM and registered outputs; data outputs hold between writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= IDLE;
         o_wen          <= 1'b0;
         o_fifo_in      <= {DATA_WIDTH_16{1'b0}};
         o_col          <= {ADDR_WIDTH{1'b0}};
         o_row          <= {ADDR_WIDTH{1'b0}};
         o_window_valid <= 1'b0;
         o_frame_end    <= 1'b0;
         o_sof_error    <= 1'b0;
      end else begin
         o_wen          <= write_s;
         o_window_valid <= write_s & (wr_row_s >= WIN_ROW_MIN) & (wr_col_s >= WIN_COL_MIN);
         o_sof_error    <= sof_take_s & (state_r == ACTIVE);
         o_frame_end    <= (state_r == DONE);
         if (write_s) begin
            o_fifo_in <= {{(DATA_WIDTH_16 - DATA_WIDTH_8){1'b0}}, i_pixel};
            o_col     <= wr_col_s;
            o_row     <= wr_row_s;
         end
         case (state_r)
            IDLE: begin
               if (sof_take_s) begin
                  state_r <= last_write_s ? DONE : ACTIVE;
               end
            end
            ACTIVE: begin
               if (last_write_s) begin
                  state_r <= DONE;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
